layer_bridge: RTL and testbench
===============================

Name: layer_bridge

Overview:
- Parametrised successor to the inter-layer glue between neuron layers: per-channel capture barrier, frame FIFO and serializer in one block.
- Accepts NUM_INPUTS values whose valids fire at arbitrary, independent times and assembles them into complete frames.
- Buffers up to DEPTH complete frames.
- Streams each frame one value per cycle into the next layer when that layer signals TRIGGER.
- Adds behaviour the current glue lacks: frame buffering, a partial-frame timeout, duplicate-arrival detection and frame-drop reporting.

Parameters:
- NUM_INPUTS, 6, number of channels (neurons) per frame, >=2.
- WIDTH, 8, fixed-point value width.
- DEPTH, 2, frame FIFO entries, power of 2, >=1.
- TIMEOUT, 0, cycles allowed from first arrival to frame completion; 0 disables the timeout.

Ports:
- CLK  in  1  clock; one clock domain.
- RST  in  1  reset; synchronous and active-high.
- VALUES_IN  in  NUM_INPUTS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- VALIDS_IN  in  NUM_INPUTS  per-channel single-cycle valid.
- TRIGGER  in  1  downstream layer ready to accept a new frame.
- VALUE_OUT  out  WIDTH  serialized value.
- VALID_OUT  out  1  VALUE_OUT valid.
- LAST_OUT  out  1  high with the final value of a frame.
- BUSY  out  1  serializer in SEND.
- FILL_LEVEL  out  $clog2(DEPTH+1)  frames held in FIFO.
- FRAME_DROP  out  1  1-cycle pulse: complete frame discarded because FIFO full.
- TIMEOUT_ERR  out  1  1-cycle pulse: partial frame discarded on timeout.
- DUP_ERR  out  1  1-cycle pulse: valid on an already-captured channel.

Behaviour:
- Reset:
  - All outputs 0; capture mask cleared; FIFO empty; state IDLE; all counters 0.
  - Reset during SEND aborts the frame; VALID_OUT is 0 in the cycle after the reset edge.
- Capture:
  - VALIDS_IN[i]=1 with mask[i]=0: store the value, set mask[i].
  - VALIDS_IN[i]=1 with mask[i]=1: keep the first value, pulse DUP_ERR.
- Completion:
  - Complete when (mask | VALIDS_IN)==all-ones.
  - The assembled frame is written to the FIFO on that edge and the mask is cleared.
  - Valids in the following cycle start the next frame.
- FIFO full on completion:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise pulse FRAME_DROP and discard the frame.
- Timeout (TIMEOUT>0):
  - Counter starts at the first arrival of a frame.
  - If it reaches TIMEOUT without completion: pulse TIMEOUT_ERR, clear the mask, discard the partial frame.
  - Completion in the same cycle as expiry wins; no error is raised.
- Serializer FSM:
  - IDLE -> SEND when FILL_LEVEL>0 and TRIGGER=1.
  - SEND: index k=0..NUM_INPUTS-1, one per cycle; VALUE_OUT = head[k*WIDTH +: WIDTH], VALID_OUT=1, BUSY=1.
  - LAST_OUT=1 at k=NUM_INPUTS-1; the head is popped on that edge and the FSM returns to IDLE.
  - TRIGGER is ignored during SEND.
  - Consecutive frames have at least one IDLE cycle between them.
- Latency:
  - Final arrival at cycle t -> frame in FIFO at t+1.
  - If TRIGGER=1 at t+1, first VALID_OUT at t+2 and LAST_OUT at t+1+NUM_INPUTS.
- FILL_LEVEL:
  - Registered.
  - Simultaneous push and pop leaves it unchanged.
- Values are passed bit-exact; no arithmetic or resizing.

Decomposition:
- Shared package holds:
  - Serializer state encoding (IDLE, SEND).
  - Width helpers: IDX_W=$clog2(NUM_INPUTS), PTR_W=$clog2(DEPTH), CNT_W=$clog2(DEPTH+1), TMO_W=$clog2(TIMEOUT+1).
- One sub-module: frame_fifo, a synchronous FIFO.
  - Word width NUM_INPUTS*WIDTH, DEPTH entries.
  - Ports: push, pop, head, count, full, empty.
  - Reused by later buffering blocks.
- Capture barrier and serializer stay in layer_bridge.

Test Plan:
- NUM_INPUTS=6, DEPTH=2, TIMEOUT=16. Staggered valids: ch0..5 at cycles 1,3,3,4,7,9 with values 0x10..0x15, TRIGGER=1 -> VALID_OUT cycles 11..16 carry 0x10..0x15 in order; LAST_OUT only at cycle 16.
- TRIGGER=0: complete 3 frames back-to-back -> FILL_LEVEL goes 1,2; third frame pulses FRAME_DROP. Then raise TRIGGER -> frames 1 and 2 stream intact, with one IDLE gap between them.
- Channels 0..4 valid at cycle 1, channel 5 never -> TIMEOUT_ERR pulses at cycle 17; FIFO stays empty. The next full frame streams normally.
- Channel 2 valid twice in one frame (0x22, then 0x55) -> DUP_ERR pulse at the second valid; the output frame carries 0x22 for ch2.
- FIFO full while the serializer pops the head and a new frame completes on the same cycle as LAST_OUT -> no FRAME_DROP; FILL_LEVEL stays 2.
- Assert RST at k=3 of a SEND -> VALID_OUT=0 in the next cycle; FILL_LEVEL=0; a new frame after reset streams correctly.

Source files
------------

// File: rtl/layer_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : layer_bridge_pkg
//  Purpose  : Shared types and width helpers for the inter-layer bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package layer_bridge_pkg;

   // Serializer state encoding
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_e;

   // Channel index width; at least one bit so the index register always exists
   function automatic int calc_idx_w(input int num_inputs);
      return (num_inputs > 1) ? $clog2(num_inputs) : 1;
   endfunction

   // FIFO pointer width; a single-entry FIFO still carries a 1-bit pointer
   function automatic int calc_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy width, able to represent 0..DEPTH
   function automatic int calc_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Timeout counter width, able to represent 0..TIMEOUT
   function automatic int calc_tmo_w(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/layer_bridge_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : frame_fifo
//  Purpose  : Synchronous FIFO holding whole frames; head is always visible.
//             A push into a full FIFO is accepted only when a pop happens on
//             the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_fifo
   import layer_bridge_pkg::*;
#(
   parameter int WORD_W = 48,
   parameter int DEPTH  = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WORD_W-1:0]            data_i,
   output logic [WORD_W-1:0]            head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int               PTR_W    = calc_ptr_w(DEPTH);
   localparam int               CNT_W    = calc_cnt_w(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              w_full;
   logic              w_empty;
   logic              w_do_push;
   logic              w_do_pop;

   assign w_full    = (count_q == CNT_W'(DEPTH));
   assign w_empty   = (count_q == '0);
   assign w_do_pop  = pop_i && !w_empty;
   // A full FIFO frees the head slot on a pop, so the push can land there
   assign w_do_push = push_i && (!w_full || w_do_pop);

   // Frame storage; contents are don't-care until written
   always_ff @(posedge clk_i) begin
      if (w_do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) begin
            wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (w_do_pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = w_full;
   assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: rtl/layer_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : layer_bridge
//  Purpose  : Glue between neuron layers: per-channel capture barrier with
//             duplicate and timeout detection, frame FIFO, and a serializer
//             that streams one value per cycle on TRIGGER.
//  Revision : 1.0 - initial release
// ============================================================================
module layer_bridge
   import layer_bridge_pkg::*;
#(
   parameter int NUM_INPUTS = 6,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 2,
   parameter int TIMEOUT    = 0
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_INPUTS*WIDTH-1:0]   VALUES_IN,
   input  logic [NUM_INPUTS-1:0]         VALIDS_IN,
   input  logic                          TRIGGER,
   output logic [WIDTH-1:0]              VALUE_OUT,
   output logic                          VALID_OUT,
   output logic                          LAST_OUT,
   output logic                          BUSY,
   output logic [$clog2(DEPTH+1)-1:0]    FILL_LEVEL,
   output logic                          FRAME_DROP,
   output logic                          TIMEOUT_ERR,
   output logic                          DUP_ERR
);

   localparam int                    FRAME_W  = NUM_INPUTS * WIDTH;
   localparam int                    IDX_W    = calc_idx_w(NUM_INPUTS);
   localparam int                    TMO_W    = calc_tmo_w(TIMEOUT);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_INPUTS - 1);
   localparam logic [NUM_INPUTS-1:0] ALL_ONES = '1;

   // Capture barrier state
   logic [NUM_INPUTS-1:0] mask_q, mask_d;
   logic [FRAME_W-1:0]    data_q, data_d;
   logic [TMO_W-1:0]      timer_q, timer_d;
   logic                  dup_q, tmo_q, drop_q;

   // Serializer state
   ser_state_e            state_q;
   logic [IDX_W-1:0]      k_q;
   logic [WIDTH-1:0]      value_q;
   logic                  valid_q, last_q, busy_q;

   logic [FRAME_W-1:0]    w_frame;
   logic                  w_complete, w_active, w_expire, w_dup;
   logic [TMO_W-1:0]      w_elapsed;
   logic [FRAME_W-1:0]    w_head;
   logic                  w_full, w_empty, w_pop;
   logic [IDX_W-1:0]      w_k_next;

   // Barrier next-state: capture first arrivals, detect completion/expiry
   always_comb begin
      w_complete = ((mask_q | VALIDS_IN) == ALL_ONES);
      w_active   = (mask_q != '0) || (VALIDS_IN != '0);
      w_dup      = |(mask_q & VALIDS_IN);
      // Cycles elapsed since the first arrival, counting the arrival cycle
      w_elapsed  = (mask_q == '0) ? TMO_W'(1) : timer_q + TMO_W'(1);
      w_expire   = (TIMEOUT != 0) && w_active && !w_complete &&
                   (w_elapsed == TMO_W'(TIMEOUT));
      w_frame    = '0;
      mask_d     = mask_q;
      data_d     = data_q;
      timer_d    = timer_q;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_frame[i*WIDTH +: WIDTH] = mask_q[i] ? data_q[i*WIDTH +: WIDTH]
                                               : VALUES_IN[i*WIDTH +: WIDTH];
      end
      if (w_complete || w_expire) begin
         mask_d  = '0;
         timer_d = '0;
      end else begin
         mask_d = mask_q | VALIDS_IN;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (VALIDS_IN[i] && !mask_q[i]) begin
               data_d[i*WIDTH +: WIDTH] = VALUES_IN[i*WIDTH +: WIDTH];
            end
         end
         timer_d = ((TIMEOUT != 0) && w_active) ? w_elapsed : '0;
      end
   end

   // Barrier registers and single-cycle error pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         mask_q  <= '0;
         data_q  <= '0;
         timer_q <= '0;
         dup_q   <= 1'b0;
         tmo_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         data_q  <= data_d;
         timer_q <= timer_d;
         dup_q   <= w_dup;
         tmo_q   <= w_expire;
         drop_q  <= w_complete && w_full && !w_pop;
      end
   end

   frame_fifo #(
      .WORD_W (FRAME_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (w_complete),
      .pop_i   (w_pop),
      .data_i  (w_frame),
      .head_o  (w_head),
      .count_o (FILL_LEVEL),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // The head leaves the FIFO on the edge that ends the LAST_OUT cycle
   assign w_pop    = (state_q == ST_SEND) && (k_q == LAST_IDX);
   assign w_k_next = k_q + IDX_W'(1);

   // Serializer FSM with registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               busy_q  <= 1'b0;
               k_q     <= '0;
               if (!w_empty && TRIGGER) begin
                  state_q <= ST_SEND;
                  value_q <= w_head[WIDTH-1:0];
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_SEND: begin
               if (k_q == LAST_IDX) begin
                  state_q <= ST_IDLE;
                  k_q     <= '0;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  k_q     <= w_k_next;
                  value_q <= w_head[w_k_next*WIDTH +: WIDTH];
                  last_q  <= (w_k_next == LAST_IDX);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign VALUE_OUT   = value_q;
   assign VALID_OUT   = valid_q;
   assign LAST_OUT    = last_q;
   assign BUSY        = busy_q;
   assign FRAME_DROP  = drop_q;
   assign TIMEOUT_ERR = tmo_q;
   assign DUP_ERR     = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_bridge
//  Purpose  : Directed self-checking bench for layer_bridge
//             (NUM_INPUTS=6, WIDTH=8, DEPTH=2, TIMEOUT=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_bridge;

   localparam int NI = 6;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NI*W-1:0] values = '0;
   logic [NI-1:0] valids = '0;
   logic          trigger = 1'b0;
   logic [W-1:0]  value_out;
   logic          valid_out, last_out, busy;
   logic [1:0]    fill_level;
   logic          frame_drop, timeout_err, dup_err;

   int n_cmp  = 0;
   int n_fail = 0;

   layer_bridge #(
      .NUM_INPUTS (NI),
      .WIDTH      (W),
      .DEPTH      (2),
      .TIMEOUT    (16)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .VALUES_IN   (values),
      .VALIDS_IN   (valids),
      .TRIGGER     (trigger),
      .VALUE_OUT   (value_out),
      .VALID_OUT   (valid_out),
      .LAST_OUT    (last_out),
      .BUSY        (busy),
      .FILL_LEVEL  (fill_level),
      .FRAME_DROP  (frame_drop),
      .TIMEOUT_ERR (timeout_err),
      .DUP_ERR     (dup_err)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Valid lanes carry base+i; idle lanes carry filler that must never appear
   task automatic drive(input logic [NI-1:0] v, input logic [7:0] base);
      valids = v;
      for (int i = 0; i < NI; i++) begin
         values[i*W +: W] = v[i] ? base + 8'(i) : 8'hEE;
      end
   endtask

   task automatic idle(input int n);
      drive('0, 8'h00);
      repeat (n) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      trigger = 1'b1;
      drive('1, 8'h00);
      step(); step();
      rst = 1'b0;
      trigger = 1'b0;
      drive('0, 8'h00);
      n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_out); end
      n_cmp++; if (value_out !== 8'h00) begin n_fail++; $display("FAIL reset_value got %h exp 00", value_out); end
      n_cmp++; if (last_out !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", last_out); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if (fill_level !== 2'd0) begin n_fail++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
      n_cmp++; if ({frame_drop, timeout_err, dup_err} !== 3'b000) begin n_fail++; $display("FAIL reset_errs got %b exp 000", {frame_drop, timeout_err, dup_err}); end
      step();
      n_cmp++; if (fill_level !== 2'd0) begin n_fail++; $display("FAIL reset_mask_clear fill got %0d exp 0", fill_level); end
      idle(2);
   endtask

   task automatic test_staggered();
      logic ev, el;
      trigger = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         step();
         case (c)
            1:       drive(6'b000001, 8'h10);
            3:       drive(6'b000110, 8'h10);
            4:       drive(6'b001000, 8'h10);
            7:       drive(6'b010000, 8'h10);
            9:       drive(6'b100000, 8'h10);
            default: drive('0, 8'h10);
         endcase
         ev = (c >= 11 && c <= 16);
         el = (c == 16);
         n_cmp++; if (valid_out !== ev) begin n_fail++; $display("FAIL stag_valid c=%0d got %b exp %b", c, valid_out, ev); end
         n_cmp++; if (busy !== ev) begin n_fail++; $display("FAIL stag_busy c=%0d got %b exp %b", c, busy, ev); end
         n_cmp++; if (last_out !== el) begin n_fail++; $display("FAIL stag_last c=%0d got %b exp %b", c, last_out, el); end
         if (ev) begin
            n_cmp++; if (value_out !== 8'h10 + 8'(c - 11)) begin n_fail++; $display("FAIL stag_value c=%0d got %h exp %h", c, value_out, 8'h10 + 8'(c - 11)); end
         end
         if (c == 10) begin
            n_cmp++; if (fill_level !== 2'd1) begin n_fail++; $display("FAIL stag_fill c=10 got %0d exp 1", fill_level); end
         end
         if (c == 17) begin
            n_cmp++; if (fill_level !== 2'd0) begin n_fail++; $display("FAIL stag_fill c=17 got %0d exp 0", fill_level); end
         end
      end
      trigger = 1'b0;
      idle(2);
   endtask

   task automatic test_drop();
      logic ev, el, ed;
      logic [7:0] ex;
      trigger = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         step();
         case (c)
            1:       drive('1, 8'hA0);
            2:       drive('1, 8'hB0);
            3:       drive('1, 8'hC0);
            default: drive('0, 8'h00);
         endcase
         trigger = (c >= 5);
         ev = (c >= 6 && c <= 11) || (c >= 13 && c <= 18);
         el = (c == 11) || (c == 18);
         ed = (c == 4);
         ex = (c <= 11) ? 8'hA0 + 8'(c - 6) : 8'hB0 + 8'(c - 13);
         n_cmp++; if (frame_drop !== ed) begin n_fail++; $display("FAIL drop_pulse c=%0d got %b exp %b", c, frame_drop, ed); end
         n_cmp++; if (valid_out !== ev) begin n_fail++; $display("FAIL drop_valid c=%0d got %b exp %b", c, valid_out, ev); end
         n_cmp++; if (last_out !== el) begin n_fail++; $display("FAIL drop_last c=%0d got %b exp %b", c, last_out, el); end
         if (ev) begin
            n_cmp++; if (value_out !== ex) begin n_fail++; $display("FAIL drop_value c=%0d got %h exp %h", c, value_out, ex); end
         end
         if (c == 2) begin
            n_cmp++; if (fill_level !== 2'd1) begin n_fail++; $display("FAIL drop_fill c=2 got %0d exp 1", fill_level); end
         end
         if (c == 3 || c == 4) begin
            n_cmp++; if (fill_level !== 2'd2) begin n_fail++; $display("FAIL drop_fill c=%0d got %0d exp 2", c, fill_level); end
         end
         if (c == 12) begin
            n_cmp++; if (fill_level !== 2'd1) begin n_fail++; $display("FAIL drop_fill c=12 got %0d exp 1", fill_level); end
         end
         if (c == 19) begin
            n_cmp++; if (fill_level !== 2'd0) begin n_fail++; $display("FAIL drop_fill c=19 got %0d exp 0", fill_level); end
         end
      end
      trigger = 1'b0;
      idle(2);
   endtask

   task automatic test_timeout();
      logic et, ev, el;
      trigger = 1'b1;
      for (int c = 1; c <= 27; c++) begin
         step();
         case (c)
            1:       drive(6'b011111, 8'h30);
            19:      drive('1, 8'h40);
            default: drive('0, 8'h00);
         endcase
         et = (c == 17);
         ev = (c >= 21 && c <= 26);
         el = (c == 26);
         n_cmp++; if (timeout_err !== et) begin n_fail++; $display("FAIL tmo_pulse c=%0d got %b exp %b", c, timeout_err, et); end
         n_cmp++; if (valid_out !== ev) begin n_fail++; $display("FAIL tmo_valid c=%0d got %b exp %b", c, valid_out, ev); end
         n_cmp++; if (last_out !== el) begin n_fail++; $display("FAIL tmo_last c=%0d got %b exp %b", c, last_out, el); end
         if (ev) begin
            n_cmp++; if (value_out !== 8'h40 + 8'(c - 21)) begin n_fail++; $display("FAIL tmo_value c=%0d got %h exp %h", c, value_out, 8'h40 + 8'(c - 21)); end
         end
         if (c <= 19) begin
            n_cmp++; if (fill_level !== 2'd0) begin n_fail++; $display("FAIL tmo_fill c=%0d got %0d exp 0", c, fill_level); end
         end
      end
      trigger = 1'b0;
      idle(2);
   endtask

   task automatic test_timeout_boundary();
      logic ev;
      trigger = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         step();
         case (c)
            1:       drive(6'b000001, 8'h50);
            16:      drive(6'b111110, 8'h50);
            default: drive('0, 8'h00);
         endcase
         ev = (c >= 18 && c <= 23);
         n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_pulse c=%0d got %b exp 0", c, timeout_err); end
         n_cmp++; if (valid_out !== ev) begin n_fail++; $display("FAIL tmo_edge_valid c=%0d got %b exp %b", c, valid_out, ev); end
         if (ev) begin
            n_cmp++; if (value_out !== 8'h50 + 8'(c - 18)) begin n_fail++; $display("FAIL tmo_edge_value c=%0d got %h exp %h", c, value_out, 8'h50 + 8'(c - 18)); end
         end
      end
      trigger = 1'b0;
      idle(2);
   endtask

   task automatic test_dup();
      logic ed, ev, el;
      trigger = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         case (c)
            1:       drive(6'b000100, 8'h20);   // ch2 = 0x22
            2:       drive(6'b000100, 8'h53);   // ch2 = 0x55 (duplicate)
            3:       drive(6'b111011, 8'h20);
            default: drive('0, 8'h00);
         endcase
         ed = (c == 3);
         ev = (c >= 5 && c <= 10);
         el = (c == 10);
         n_cmp++; if (dup_err !== ed) begin n_fail++; $display("FAIL dup_pulse c=%0d got %b exp %b", c, dup_err, ed); end
         n_cmp++; if (valid_out !== ev) begin n_fail++; $display("FAIL dup_valid c=%0d got %b exp %b", c, valid_out, ev); end
         n_cmp++; if (last_out !== el) begin n_fail++; $display("FAIL dup_last c=%0d got %b exp %b", c, last_out, el); end
         if (ev) begin
            n_cmp++; if (value_out !== 8'h20 + 8'(c - 5)) begin n_fail++; $display("FAIL dup_value c=%0d got %h exp %h", c, value_out, 8'h20 + 8'(c - 5)); end
         end
      end
      trigger = 1'b0;
      idle(2);
   endtask

   task automatic test_full_pop_push();
      logic ev, el;
      logic [7:0] ex;
      logic [1:0] ef;
      for (int c = 1; c <= 24; c++) begin
         step();
         case (c)
            1:       drive('1, 8'h60);
            2:       drive('1, 8'h70);
            9:       drive('1, 8'h80);
            default: drive('0, 8'h00);
         endcase
         trigger = (c == 3) || (c >= 10);
         ev = (c >= 4 && c <= 9) || (c >= 11 && c <= 16) || (c >= 18 && c <= 23);
         el = (c == 9) || (c == 16) || (c == 23);
         ex = (c <= 9) ? 8'h60 + 8'(c - 4) : (c <= 16) ? 8'h70 + 8'(c - 11) : 8'h80 + 8'(c - 18);
         ef = (c == 2 || c >= 17) ? 2'd1 : 2'd2;
         if (c == 24) ef = 2'd0;
         n_cmp++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL fpp_drop c=%0d got %b exp 0", c, frame_drop); end
         n_cmp++; if (valid_out !== ev) begin n_fail++; $display("FAIL fpp_valid c=%0d got %b exp %b", c, valid_out, ev); end
         n_cmp++; if (last_out !== el) begin n_fail++; $display("FAIL fpp_last c=%0d got %b exp %b", c, last_out, el); end
         if (ev) begin
            n_cmp++; if (value_out !== ex) begin n_fail++; $display("FAIL fpp_value c=%0d got %h exp %h", c, value_out, ex); end
         end
         if (c >= 2) begin
            n_cmp++; if (fill_level !== ef) begin n_fail++; $display("FAIL fpp_fill c=%0d got %0d exp %0d", c, fill_level, ef); end
         end
      end
      trigger = 1'b0;
      idle(2);
   endtask

   task automatic test_reset_mid_send();
      logic ev, el;
      logic [7:0] ex;
      trigger = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         step();
         case (c)
            1:       drive('1, 8'h90);
            2:       drive('1, 8'hC0);
            8:       drive('1, 8'hB0);
            default: drive('0, 8'h00);
         endcase
         rst = (c == 6);
         ev = (c >= 3 && c <= 6) || (c >= 10 && c <= 15);
         el = (c == 15);
         ex = (c <= 6) ? 8'h90 + 8'(c - 3) : 8'hB0 + 8'(c - 10);
         n_cmp++; if (valid_out !== ev) begin n_fail++; $display("FAIL rst_valid c=%0d got %b exp %b", c, valid_out, ev); end
         n_cmp++; if (busy !== ev) begin n_fail++; $display("FAIL rst_busy c=%0d got %b exp %b", c, busy, ev); end
         n_cmp++; if (last_out !== el) begin n_fail++; $display("FAIL rst_last c=%0d got %b exp %b", c, last_out, el); end
         if (ev) begin
            n_cmp++; if (value_out !== ex) begin n_fail++; $display("FAIL rst_value c=%0d got %h exp %h", c, value_out, ex); end
         end
         if (c == 4) begin
            n_cmp++; if (fill_level !== 2'd2) begin n_fail++; $display("FAIL rst_fill c=4 got %0d exp 2", fill_level); end
         end
         if (c == 7) begin
            n_cmp++; if (fill_level !== 2'd0) begin n_fail++; $display("FAIL rst_fill c=7 got %0d exp 0", fill_level); end
         end
      end
      rst = 1'b0;
      trigger = 1'b0;
      idle(2);
   endtask

   initial begin
      test_reset();
      test_staggered();
      test_drop();
      test_timeout();
      test_timeout_boundary();
      test_dup();
      test_full_pop_push();
      test_reset_mid_send();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
